// File: rtl/act_mem_readback.sv
// ----------------------------------------------------------------------------
// act_mem_readback
//
// Drains a contiguous region of the activation memory through its external
// read port and presents the words on a valid/ready stream. Reads are
// credit-limited against the output FIFO, so back-pressure never drops a word.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle launch pulse (only honoured in IDLE)
//   base_addr             first word address (low ADDR_SIZE bits used)
//   word_count            number of words to read (0 finishes at once)
//   rd_en_ext_act_mem     read strobe to the activation memory
//   rd_addr_ext_act_mem   read address, zero-extended from ADDR_SIZE
//   rd_data_ext_act_mem   read data, valid RD_LATENCY cycles after strobe
//   out_valid/out_ready   stream handshake
//   out_data              stream word (FIFO head)
//   out_last              marks the final word of the readback
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse after the final word is accepted
// ----------------------------------------------------------------------------
module act_mem_readback #(
   parameter int ADDR_SIZE  = 16,
   parameter int DATA_WIDTH = 64,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           base_addr,
   input  logic [31:0]           word_count,
   output logic                  rd_en_ext_act_mem,
   output logic [31:0]           rd_addr_ext_act_mem,
   input  logic [DATA_WIDTH-1:0] rd_data_ext_act_mem,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_SIZE-1:0]    rd_ptr_q, rd_ptr_d;
   logic [31:0]             issue_left_q, issue_left_d;
   logic [31:0]             out_left_q, out_left_d;
   logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
   logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]   fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]        fifo_wptr_q, fifo_wptr_d;
   logic [PTR_W-1:0]        fifo_rptr_q, fifo_rptr_d;
   logic [CNT_W-1:0]        fifo_count_q, fifo_count_d;

   logic                    start_ok;
   logic [CNT_W-1:0]        in_flight;
   logic [CNT_W:0]          credit_sum;
   logic                    fifo_wr;
   logic                    fifo_rd;
   logic                    unused_base_bits;

   // Address bits above ADDR_SIZE are deliberately ignored.
   assign unused_base_bits = ^base_addr[31:ADDR_SIZE];

   // Stream side comes straight from registered FIFO state, so out_valid
   // never depends combinationally on out_ready.
   assign start_ok            = (state_q == IDLE) && start;
   assign out_valid           = (fifo_count_q != '0);
   assign out_data            = fifo_mem_q[fifo_rptr_q];
   assign out_last            = out_valid && (out_left_q == 32'd1);
   assign fifo_wr             = pipe_q[RD_LATENCY-1];
   assign fifo_rd             = out_valid && out_ready;
   assign rd_addr_ext_act_mem = 32'(rd_ptr_q);

   // Reads already launched but not yet landed in the FIFO still own a slot,
   // so the credit check adds them to the FIFO occupancy.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         in_flight = in_flight + CNT_W'(pipe_q[i]);
      end
      credit_sum = {1'b0, fifo_count_q} + {1'b0, in_flight};
   end

   // State register plus all datapath flops; reset also flushes the strobe
   // pipeline so data returning from aborted reads is never captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rd_ptr_q     <= '0;
         issue_left_q <= '0;
         out_left_q   <= '0;
         pipe_q       <= '0;
         fifo_wptr_q  <= '0;
         fifo_rptr_q  <= '0;
         fifo_count_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rd_ptr_q     <= rd_ptr_d;
         issue_left_q <= issue_left_d;
         out_left_q   <= out_left_d;
         pipe_q       <= pipe_d;
         fifo_wptr_q  <= fifo_wptr_d;
         fifo_rptr_q  <= fifo_rptr_d;
         fifo_count_q <= fifo_count_d;
         fifo_mem_q   <= fifo_mem_d;
      end
   end

   // Next-state logic. A zero-length request skips straight to DONE; the
   // issue phase ends on the read that consumes the last issue credit and
   // the drain phase ends on the handshake of the last word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (word_count == 32'd0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (rd_en_ext_act_mem && (issue_left_q == 32'd1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_rd && (out_left_q == 32'd1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs. The read strobe only looks at registered occupancy, which
   // keeps out_ready off the memory-side timing path.
   always_comb begin
      rd_en_ext_act_mem = (state_q == ISSUE) && (issue_left_q != 32'd0) &&
                          (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
      busy              = (state_q != IDLE);
      done              = (state_q == DONE);
   end

   // Pointer/counter updates, strobe pipeline and FIFO bookkeeping. A
   // simultaneous write and pop leaves the occupancy unchanged.
   always_comb begin
      rd_ptr_d     = rd_ptr_q;
      issue_left_d = issue_left_q;
      out_left_d   = out_left_q;
      fifo_wptr_d  = fifo_wptr_q;
      fifo_rptr_d  = fifo_rptr_q;
      fifo_count_d = fifo_count_q;
      fifo_mem_d   = fifo_mem_q;

      if (start_ok) begin
         rd_ptr_d     = base_addr[ADDR_SIZE-1:0];
         issue_left_d = word_count;
         out_left_d   = word_count;
      end else begin
         if (rd_en_ext_act_mem) begin
            rd_ptr_d     = rd_ptr_q + ADDR_SIZE'(1);
            issue_left_d = issue_left_q - 32'd1;
         end
         if (fifo_rd) begin
            out_left_d = out_left_q - 32'd1;
         end
      end

      pipe_d[0] = rd_en_ext_act_mem;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      if (fifo_wr) begin
         fifo_mem_d[fifo_wptr_q] = rd_data_ext_act_mem;
         fifo_wptr_d             = fifo_wptr_q + PTR_W'(1);
      end
      if (fifo_rd) begin
         fifo_rptr_d = fifo_rptr_q + PTR_W'(1);
      end
      case ({fifo_wr, fifo_rd})
         2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
         2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   // The credit rule makes a write into a full FIFO impossible; if it ever
   // happens a word would be lost.
   a_no_fifo_overflow : assert property (@(posedge clk) disable iff (reset)
      !(fifo_wr && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

endmodule
